// File: rtl/rv32i_fetch_ctrl_if.sv
// Signal bundle between the fetch controller and its neighbours:
// ProgramCounter controls, instruction-memory port, redirect input,
// decode-side handshake and trap reporting.
interface rv32i_fetch_ctrl_if;
  logic [31:0] pc_out;
  logic [31:0] pc_in;
  logic        pc_ld;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        trap_pulse;
  logic [31:0] trap_addr;

  // The fetch controller side
  modport master (
    input  pc_out, imem_ack, imem_rdata, redir_valid, redir_target, inst_ready,
    output pc_in, pc_ld, imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    trap_pulse, trap_addr
  );

  // The environment side (PC, memory, execute, decode)
  modport slave (
    output pc_out, imem_ack, imem_rdata, redir_valid, redir_target, inst_ready,
    input  pc_in, pc_ld, imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    trap_pulse, trap_addr
  );
endinterface

// File: rtl/rv32i_fetch_ctrl.sv
// Fetch sequencer: steers the ProgramCounter (hold / +4 / load), issues
// instruction fetches at the current PC, buffers one instruction for decode
// and applies execute redirects, trapping misaligned targets.
module rv32i_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h00000100
) (
  input logic              clk,
  input logic              reset,
  rv32i_fetch_ctrl_if.master bus
);

  localparam logic [0:0] BOOT  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]  state_reg;
  logic        inst_valid_reg;
  logic [31:0] inst_data_reg;
  logic [31:0] inst_pc_reg;
  logic        trap_pulse_reg;
  logic [31:0] trap_addr_reg;

  logic in_fetch;
  logic can_accept;
  logic redir_take;
  logic redir_misaligned;
  logic capture;

  assign in_fetch         = (state_reg == FETCH);
  // Buffer takes a new word when empty or when decode drains it this cycle
  assign can_accept       = !inst_valid_reg || bus.inst_ready;
  assign redir_take       = in_fetch && bus.redir_valid;
  assign redir_misaligned = (bus.redir_target[1:0] != 2'b00);
  // A redirect discards any same-cycle fetch completion
  assign capture          = in_fetch && !bus.redir_valid && bus.imem_ack && can_accept;

  assign bus.imem_req   = in_fetch;
  assign bus.imem_addr  = bus.pc_out;
  assign bus.inst_valid = inst_valid_reg;
  assign bus.inst_data  = inst_data_reg;
  assign bus.inst_pc    = inst_pc_reg;
  assign bus.trap_pulse = trap_pulse_reg;
  assign bus.trap_addr  = trap_addr_reg;

  // PC control: the PC self-increments when ld=0, so every non-advancing
  // cycle reloads the current value to hold it
  always_comb begin
    bus.pc_ld = 1'b0;
    bus.pc_in = 32'h0;
    if (!reset) begin
      bus.pc_ld = 1'b0;
      bus.pc_in = 32'h0;
    end else if (!in_fetch) begin
      bus.pc_ld = 1'b1;
      bus.pc_in = RESET_VECTOR;
    end else if (bus.redir_valid) begin
      bus.pc_ld = 1'b1;
      bus.pc_in = redir_misaligned ? TRAP_VECTOR : bus.redir_target;
    end else if (capture) begin
      bus.pc_ld = 1'b0;
      bus.pc_in = bus.pc_out;
    end else begin
      bus.pc_ld = 1'b1;
      bus.pc_in = bus.pc_out;
    end
  end

  // State: BOOT for exactly one cycle after reset, then FETCH forever
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= FETCH;
    end
  end

  // Instruction buffer: flush on redirect, fill on accepted fetch, else drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_valid_reg <= 1'b0;
      inst_data_reg  <= 32'h0;
      inst_pc_reg    <= 32'h0;
    end else if (redir_take) begin
      inst_valid_reg <= 1'b0;
    end else if (capture) begin
      inst_valid_reg <= 1'b1;
      inst_data_reg  <= bus.imem_rdata;
      inst_pc_reg    <= bus.pc_out;
    end else if (inst_valid_reg && bus.inst_ready) begin
      inst_valid_reg <= 1'b0;
    end
  end

  // Trap reporting: one-cycle pulse and sticky offending address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_pulse_reg <= 1'b0;
      trap_addr_reg  <= 32'h0;
    end else begin
      trap_pulse_reg <= redir_take && redir_misaligned;
      if (redir_take && redir_misaligned) begin
        trap_addr_reg <= bus.redir_target;
      end
    end
  end

endmodule

// File: doc/rv32i_fetch_ctrl.md
Name: rv32i_fetch_ctrl

Overview:
- Fetch sequencer that owns the ProgramCounter's `ld` and `in` controls and decides every cycle whether the PC holds, advances by 4 or loads a new target.
- Issues instruction-memory reads at the current PC and buffers one fetched instruction for decode, with a valid/ready handshake.
- Applies branch/jump redirects from execute and traps misaligned redirect targets to a fixed vector.
- Sits between ProgramCounter, the instruction memory port and the decode stage.

Parameters:
RESET_VECTOR, 32'h00000000, PC loaded on the first cycle after reset release
TRAP_VECTOR, 32'h00000100, PC loaded when a redirect target is misaligned

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
pc_out  input  32  current PC, from ProgramCounter `out`
pc_in  output  32  load value, to ProgramCounter `in`
pc_ld  output  1  load strobe, to ProgramCounter `ld`; when 0 the PC advances by 4
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, always equal to pc_out
imem_ack  input  1  fetch complete; imem_rdata is valid for imem_addr in this same cycle
imem_rdata  input  32  fetched instruction word
redir_valid  input  1  redirect request from execute (branch taken or jump)
redir_target  input  32  redirect target address
inst_valid  output  1  buffered instruction is available to decode
inst_ready  input  1  decode accepts the buffered instruction
inst_data  output  32  buffered instruction word
inst_pc  output  32  address of the buffered instruction
trap_pulse  output  1  one-cycle pulse: misaligned redirect was taken
trap_addr  output  32  offending target, captured on the trap

Behaviour:
- Reset (asynchronous, reset=0):
  - All registered outputs are cleared: imem_req=0, inst_valid=0, trap_pulse=0, trap_addr=0, inst_data=0, inst_pc=0.
  - pc_ld=0 and pc_in=0 (the PC clears itself). The state machine goes to BOOT.
- Hold rule: ProgramCounter increments whenever ld=0, so the controller drives pc_ld=1 with pc_in=pc_out in every cycle the PC must not move. pc_ld and pc_in are combinational from state and inputs.
- BOOT, entered once after reset release:
  - pc_ld=1, pc_in=RESET_VECTOR, imem_req=0.
  - Next state is FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc_out.
  - The buffer "can accept" when !inst_valid, or when inst_valid && inst_ready (drain and fill in the same cycle).
  - If imem_ack and the buffer can accept: capture inst_data<=imem_rdata, inst_pc<=pc_out, inst_valid<=1, and drive pc_ld=0 so the PC advances by 4. Sustained throughput is 1 instruction per cycle.
  - If imem_ack and the buffer is full and not draining: the fetched data is dropped and the PC is held; the fetch repeats at the same address next cycle.
  - If there is no ack: the PC is held and imem_req stays 1.
- Buffer drain: inst_valid && inst_ready with no refill that cycle gives inst_valid<=0. While inst_valid && !inst_ready, inst_data and inst_pc are stable.
- Redirect (redir_valid=1 in FETCH) has the highest priority over everything else:
  - If redir_target[1:0]==0: pc_ld=1, pc_in=redir_target.
  - The buffer is flushed: inst_valid<=0, even if inst_ready is asserted that cycle.
  - An imem_ack in the same cycle is ignored; no capture and no advance.
  - Fetch resumes at the target on the next cycle.
- Misaligned redirect (redir_target[1:0]!=0):
  - pc_ld=1, pc_in=TRAP_VECTOR, trap_addr<=redir_target.
  - trap_pulse is 1 for the following cycle only. The buffer is flushed.
- redir_valid during BOOT is ignored; the BOOT load wins.
- Back-to-back redirects: each one reloads the PC; the last one wins. Each misaligned redirect produces its own trap pulse.
- PC wrap: 32'hFFFFFFFC + 4 wraps to 0 with no special handling.
- Reset asserted mid-fetch: the outstanding request is abandoned and the buffer is cleared. There are no glitch requirements beyond the asynchronous clear.

Test Plan:
- Reset release, RESET_VECTOR=32'h00000080, imem_ack tied to 1, inst_ready=1 -> BOOT loads 0x80; inst_pc sequence 0x80, 0x84, 0x88, one per cycle; inst_valid stays high.
- imem_ack held low for 3 cycles -> pc_out stays 0x80, imem_req=1 throughout, inst_valid=0; on the first ack inst_data=imem_rdata and inst_pc=0x80.
- inst_ready low for 4 cycles with ack=1 -> inst_data/inst_pc frozen at 0x84, pc_out stays 0x88; when ready returns, 0x88 is captured the same cycle.
- redir_valid with target 0x200 while inst_valid=1 and ack=1 -> next cycle inst_valid=0, pc_out=0x200; next instruction has inst_pc=0x200.
- redir_valid with target 0x206 -> pc_out=0x100, trap_pulse high exactly 1 cycle, trap_addr=0x206, buffer flushed.
- reset asserted while inst_valid=1 -> inst_valid, imem_req and trap_pulse drop to 0 immediately; after release, BOOT refetches from RESET_VECTOR.
